matrix_write_arbiter: RTL and testbench

//  N-channel round-robin arbiter in front of the single matrix writer. Channels are executors, UART input and the random generator.

---
 rtl/matrix_write_arbiter_pkg.sv | 30 +++
 rtl/matrix_write_arbiter_if.sv | 43 ++++
 rtl/matrix_write_arbiter_rr_picker.sv | 42 ++++
 rtl/matrix_write_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_matrix_write_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// Package: matrix_write_arb_pkg
// Purpose: shared types and field widths for the matrix write arbiter slice.
//   arb_state_t  - arbiter FSM states
//   MATRIX_ID_W  - matrix id width
//   DIM_W        - rows/cols width
//   NAME_W       - matrix name width (8 bytes)
//   BEAT_W       - data beat counter width
//   beat_limit() - number of elements in a rows x cols matrix, in BEAT_W bits
// ----------------------------------------------------------------------------
package matrix_write_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STREAM,
        FINISH
    } arb_state_t;

    localparam int MATRIX_ID_W = 3;
    localparam int DIM_W       = 8;
    localparam int NAME_W      = 64;
    localparam int BEAT_W      = 16;

    function automatic logic [BEAT_W-1:0] beat_limit(input logic [DIM_W-1:0] rows,
                                                     input logic [DIM_W-1:0] cols);
        return BEAT_W'(rows) * BEAT_W'(cols);
    endfunction

endpackage

// File: rtl/matrix_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// Interface: matrix_write_arbiter_if
// Purpose: arbiter <-> matrix writer bus.
//   write_request     arbiter -> writer  request a new matrix write
//   write_ready       writer  -> arbiter writer idle, dropped on accept
//   write_matrix_id   arbiter -> writer  latched header: matrix id
//   write_rows        arbiter -> writer  latched header: rows
//   write_cols        arbiter -> writer  latched header: cols
//   write_name        arbiter -> writer  latched header: name, byte0 in [7:0]
//   write_data        arbiter -> writer  registered element
//   write_data_valid  arbiter -> writer  registered element strobe
//   write_done        writer  -> arbiter completion pulse
// Modports: master (arbiter side), slave (writer side).
// ----------------------------------------------------------------------------
interface matrix_write_arbiter_if
    import matrix_write_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) ();

    logic                   write_request;
    logic                   write_ready;
    logic [MATRIX_ID_W-1:0] write_matrix_id;
    logic [DIM_W-1:0]       write_rows;
    logic [DIM_W-1:0]       write_cols;
    logic [NAME_W-1:0]      write_name;
    logic [DATA_WIDTH-1:0]  write_data;
    logic                   write_data_valid;
    logic                   write_done;

    modport master (
        output write_request, write_matrix_id, write_rows, write_cols, write_name,
               write_data, write_data_valid,
        input  write_ready, write_done
    );

    modport slave (
        input  write_request, write_matrix_id, write_rows, write_cols, write_name,
               write_data, write_data_valid,
        output write_ready, write_done
    );

endinterface

// File: rtl/matrix_write_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// Module: matrix_write_rr_picker (combinational)
// Purpose: round-robin selection of the first requester after the pointer,
//          wrapping around NUM_CH.
// Ports:
//   req      in  NUM_CH  request vector
//   ptr      in  IDX_W   last served channel (lowest priority)
//   grant    out NUM_CH  one-hot winner
//   idx      out IDX_W   binary winner index
//   any_req  out 1       at least one request present
// ----------------------------------------------------------------------------
module matrix_write_rr_picker #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any_req
);

    // Scan from ptr+1 upward so the channel at ptr is considered last.
    always_comb begin
        logic found;
        int   cand;
        grant   = '0;
        idx     = '0;
        any_req = |req;
        found   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (int'(ptr) + i) % NUM_CH;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/matrix_write_arbiter.sv
// ----------------------------------------------------------------------------
// Module: matrix_write_arbiter
// Purpose: NUM_CH-channel round-robin arbiter in front of the single matrix
//   writer. Latches the winner's header, forwards its data stream with one
//   cycle latency, drops beats beyond rows*cols and reports done/error per
//   channel.
// Parameters: NUM_CH (>=2), DATA_WIDTH, TIMEOUT_CYCLES (watchdog only).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ch_write_request    per-channel request (held with header until grant)
//   ch_matrix_id/rows/cols/name  flattened per-channel header
//   ch_data/ch_data_valid        flattened per-channel element stream
//   ch_grant            one-hot, high from grant through completion
//   ch_write_done       1-cycle completion pulse
//   ch_error            1-cycle pulse: zero size, overflow or timeout
//   wr                  writer bus (matrix_write_arbiter_if.master)
//   busy                FSM not idle
// Configuration: define MATRIX_WRITE_TIMEOUT_EN to enable the writer
//   watchdog; without it the arbiter waits for write_done indefinitely.
// ----------------------------------------------------------------------------
module matrix_write_arbiter
    import matrix_write_arb_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_write_request,
    input  logic [NUM_CH*MATRIX_ID_W-1:0] ch_matrix_id,
    input  logic [NUM_CH*DIM_W-1:0]       ch_rows,
    input  logic [NUM_CH*DIM_W-1:0]       ch_cols,
    input  logic [NUM_CH*NAME_W-1:0]      ch_name,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_data,
    input  logic [NUM_CH-1:0]             ch_data_valid,
    output logic [NUM_CH-1:0]             ch_grant,
    output logic [NUM_CH-1:0]             ch_write_done,
    output logic [NUM_CH-1:0]             ch_error,
    matrix_write_arbiter_if.master        wr,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_CH);

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] limit;
    logic              ovf;

    logic [NUM_CH-1:0] pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [DIM_W-1:0]  pick_rows;
    logic [DIM_W-1:0]  pick_cols;

    logic                  g_valid;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  timeout_hit;

    matrix_write_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req     (ch_write_request),
        .ptr     (ptr),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign pick_rows = ch_rows[pick_idx*DIM_W +: DIM_W];
    assign pick_cols = ch_cols[pick_idx*DIM_W +: DIM_W];
    assign g_valid   = ch_data_valid[gnt_idx];
    assign g_data    = ch_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign limit     = beat_limit(wr.write_rows, wr.write_cols);
    assign busy      = (state != IDLE);

`ifdef MATRIX_WRITE_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Watchdog runs only while the writer owns the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == REQ || state == STREAM) begin
            wd_cnt <= wd_cnt + 32'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout_hit = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: the comparison is constant false for any legal limit.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Main FSM. done/error/data_valid are single-cycle pulses, so they
    // default to 0 and are set only on the cycle they apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            ptr                 <= IDX_W'(NUM_CH - 1);
            gnt_idx             <= '0;
            beat_cnt            <= '0;
            ovf                 <= 1'b0;
            ch_grant            <= '0;
            ch_write_done       <= '0;
            ch_error            <= '0;
            wr.write_request    <= 1'b0;
            wr.write_matrix_id  <= '0;
            wr.write_rows       <= '0;
            wr.write_cols       <= '0;
            wr.write_name       <= '0;
            wr.write_data       <= '0;
            wr.write_data_valid <= 1'b0;
        end else begin
            ch_write_done       <= '0;
            ch_error            <= '0;
            wr.write_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr.write_ready && pick_any) begin
                        gnt_idx            <= pick_idx;
                        beat_cnt           <= '0;
                        ovf                <= 1'b0;
                        wr.write_matrix_id <= ch_matrix_id[pick_idx*MATRIX_ID_W +: MATRIX_ID_W];
                        wr.write_rows      <= pick_rows;
                        wr.write_cols      <= pick_cols;
                        wr.write_name      <= ch_name[pick_idx*NAME_W +: NAME_W];
                        // An empty matrix never reaches the writer; the error
                        // pulse is what releases the requesting channel.
                        if (pick_rows == '0 || pick_cols == '0) begin
                            ch_error <= pick_grant;
                            ptr      <= pick_idx;
                        end else begin
                            ch_grant         <= pick_grant;
                            wr.write_request <= 1'b1;
                            state            <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (wr.write_done) begin
                        ch_write_done    <= ch_grant;
                        ch_error         <= ovf ? ch_grant : '0;
                        wr.write_request <= 1'b0;
                        state            <= FINISH;
                    end else if (timeout_hit) begin
                        ch_error         <= ch_grant;
                        wr.write_request <= 1'b0;
                        state            <= FINISH;
                    end else if (!wr.write_ready) begin
                        wr.write_request <= 1'b0;
                        beat_cnt         <= '0;
                        state            <= STREAM;
                    end
                end
                STREAM: begin
                    // A beat coinciding with write_done is dropped silently.
                    if (wr.write_done) begin
                        ch_write_done <= ch_grant;
                        ch_error      <= ovf ? ch_grant : '0;
                        state         <= FINISH;
                    end else if (timeout_hit) begin
                        ch_error <= ch_grant;
                        state    <= FINISH;
                    end else if (g_valid) begin
                        if (beat_cnt < limit) begin
                            wr.write_data       <= g_data;
                            wr.write_data_valid <= 1'b1;
                            beat_cnt            <= beat_cnt + BEAT_W'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    ch_grant <= '0;
                    ptr      <= gnt_idx;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_write_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench: tb_matrix_write_arbiter
// Directed and randomized transfers against a behavioural round-robin /
// element-count model. Writer side of the bus is driven by the bench.
// ----------------------------------------------------------------------------
module tb_matrix_write_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]    ch_write_request;
    logic [NUM_CH*3-1:0]  ch_matrix_id;
    logic [NUM_CH*8-1:0]  ch_rows;
    logic [NUM_CH*8-1:0]  ch_cols;
    logic [NUM_CH*64-1:0] ch_name;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_data_valid;
    logic [NUM_CH-1:0]    ch_grant;
    logic [NUM_CH-1:0]    ch_write_done;
    logic [NUM_CH-1:0]    ch_error;
    logic                 busy;

    matrix_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    matrix_write_arbiter #(
        .NUM_CH         (NUM_CH),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ch_write_request (ch_write_request),
        .ch_matrix_id     (ch_matrix_id),
        .ch_rows          (ch_rows),
        .ch_cols          (ch_cols),
        .ch_name          (ch_name),
        .ch_data          (ch_data),
        .ch_data_valid    (ch_data_valid),
        .ch_grant         (ch_grant),
        .ch_write_done    (ch_write_done),
        .ch_error         (ch_error),
        .wr               (bus),
        .busy             (busy)
    );

    // Bench-side channel state and reference model
    logic [NUM_CH-1:0] m_req;
    int                m_ptr;
    logic [2:0]        h_id   [NUM_CH];
    logic [7:0]        h_rows [NUM_CH];
    logic [7:0]        h_cols [NUM_CH];
    logic [63:0]       h_name [NUM_CH];
    logic [DW-1:0]     d_val  [NUM_CH];
    logic [NUM_CH-1:0] v_val;

    int total = 0;
    int bad   = 0;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic driveInputs();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_write_request[i]    = m_req[i];
            ch_matrix_id[i*3 +: 3] = h_id[i];
            ch_rows[i*8 +: 8]      = h_rows[i];
            ch_cols[i*8 +: 8]      = h_cols[i];
            ch_name[i*64 +: 64]    = h_name[i];
            ch_data[i*DW +: DW]    = d_val[i];
            ch_data_valid[i]       = v_val[i];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] oneHot(input int c);
        logic [NUM_CH-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first pending channel after the last one served.
    function automatic int modelPick();
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_ptr + k) % NUM_CH;
            if (m_req[c]) return c;
        end
        return -1;
    endfunction

    task automatic setRequest(input int c, input int rows, input int cols);
        if (!m_req[c]) begin
            h_id[c]   = 3'($urandom_range(0, 7));
            h_rows[c] = 8'(rows);
            h_cols[c] = 8'(cols);
            h_name[c] = {$urandom, $urandom};
            m_req[c]  = 1'b1;
        end
    endtask

    // One full arbitration + transfer for whichever channel the model says
    // wins. Entered and left at a negedge with the arbiter idle.
    task automatic applyStimulus(input int nbeats, input bit gaps, input bit seq_data);
        int w;
        int limit;
        int sent;
        int fwd;
        bit fwd_now;
        w = modelPick();
        if (w < 0) begin
            $display("[TB] no pending requester, step skipped");
            return;
        end
        @(negedge clk);
        checkOutput("grant", ch_grant, oneHot(w));
        checkOutput("write_request", bus.write_request, 1);
        checkOutput("hdr_id", bus.write_matrix_id, h_id[w]);
        checkOutput("hdr_rows", bus.write_rows, h_rows[w]);
        checkOutput("hdr_cols", bus.write_cols, h_cols[w]);
        checkOutput("hdr_name", bus.write_name, h_name[w]);
        checkOutput("busy_req", busy, 1);
        m_req[w]        = 1'b0;
        bus.write_ready = 1'b0;
        driveInputs();
        @(negedge clk);
        checkOutput("request_dropped", bus.write_request, 0);
        limit = int'(h_rows[w]) * int'(h_cols[w]);
        sent  = 0;
        fwd   = 0;
        while (sent < nbeats) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (i != w) begin
                    v_val[i] = 1'($urandom_range(0, 1));
                    d_val[i] = $urandom;
                end
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                v_val[w] = 1'b0;
                fwd_now  = 1'b0;
            end else begin
                v_val[w] = 1'b1;
                d_val[w] = seq_data ? DW'(sent + 1) : $urandom;
                fwd_now  = (fwd < limit);
                if (fwd_now) fwd++;
                sent++;
            end
            driveInputs();
            @(negedge clk);
            checkOutput("data_valid", bus.write_data_valid, fwd_now);
            if (fwd_now) checkOutput("data", bus.write_data, d_val[w]);
        end
        v_val           = '0;
        v_val[w]        = 1'b1;
        d_val[w]        = $urandom;
        bus.write_done  = 1'b1;
        bus.write_ready = 1'b1;
        driveInputs();
        @(negedge clk);
        bus.write_done = 1'b0;
        v_val          = '0;
        driveInputs();
        checkOutput("done_beat_dropped", bus.write_data_valid, 0);
        checkOutput("write_done_pulse", ch_write_done, oneHot(w));
        checkOutput("error_pulse", ch_error, (nbeats > limit) ? oneHot(w) : '0);
        checkOutput("grant_hold", ch_grant, oneHot(w));
        @(negedge clk);
        checkOutput("grant_release", ch_grant, 0);
        checkOutput("done_cleared", ch_write_done, 0);
        checkOutput("error_cleared", ch_error, 0);
        checkOutput("busy_idle", busy, 0);
        m_ptr = w;
    endtask

    initial begin
        int w;
        int nb;
        int cycles;
        m_req = '0;
        v_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            h_id[i]   = '0;
            h_rows[i] = '0;
            h_cols[i] = '0;
            h_name[i] = '0;
            d_val[i]  = '0;
        end
        rst             = 1'b1;
        bus.write_ready = 1'b1;
        bus.write_done  = 1'b0;
        driveInputs();
        repeat (2) @(negedge clk);
        checkOutput("rst_grant", ch_grant, 0);
        checkOutput("rst_done", ch_write_done, 0);
        checkOutput("rst_error", ch_error, 0);
        checkOutput("rst_write_request", bus.write_request, 0);
        checkOutput("rst_data_valid", bus.write_data_valid, 0);
        checkOutput("rst_busy", busy, 0);
        rst   = 1'b0;
        m_ptr = NUM_CH - 1;

        $display("[TB] T1 single 2x2 transfer");
        setRequest(0, 2, 2);
        driveInputs();
        applyStimulus(4, 1'b0, 1'b1);

        $display("[TB] T2 round-robin between ch1 and ch2");
        for (int r = 0; r < 2; r++) begin
            setRequest(1, 2, 1);
            setRequest(2, 1, 2);
            driveInputs();
            applyStimulus(2, 1'b1, 1'b0);
            applyStimulus(2, 1'b0, 1'b0);
        end

        $display("[TB] T3 overflow on ch3");
        setRequest(3, 1, 3);
        driveInputs();
        applyStimulus(5, 1'b0, 1'b0);

        $display("[TB] T4 zero-size request");
        setRequest(0, 0, 4);
        driveInputs();
        @(negedge clk);
        checkOutput("zero_error", ch_error, oneHot(0));
        checkOutput("zero_no_request", bus.write_request, 0);
        checkOutput("zero_no_grant", ch_grant, 0);
        checkOutput("zero_busy", busy, 0);
        m_req[0] = 1'b0;
        m_ptr    = 0;
        setRequest(1, 2, 1);
        driveInputs();
        applyStimulus(2, 1'b1, 1'b0);

        $display("[TB] random transfers");
        for (int n = 0; n < 10; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 1) == 1) setRequest(c, $urandom_range(1, 3), $urandom_range(1, 3));
            end
            if (m_req == '0) setRequest($urandom_range(0, NUM_CH - 1), 2, 2);
            driveInputs();
            w  = modelPick();
            nb = $urandom_range(0, int'(h_rows[w]) * int'(h_cols[w]) + 2);
            applyStimulus(nb, 1'($urandom_range(0, 1)), 1'b0);
        end
        while (m_req != '0) applyStimulus(1, 1'b0, 1'b0);

        $display("[TB] T5 reset mid-stream");
        setRequest(2, 2, 2);
        driveInputs();
        @(negedge clk);
        checkOutput("t5_grant", ch_grant, oneHot(2));
        m_req[2]        = 1'b0;
        bus.write_ready = 1'b0;
        driveInputs();
        @(negedge clk);
        v_val[2] = 1'b1;
        d_val[2] = $urandom;
        driveInputs();
        @(negedge clk);
        checkOutput("t5_data_valid", bus.write_data_valid, 1);
        rst   = 1'b1;
        v_val = '0;
        driveInputs();
        @(negedge clk);
        checkOutput("t5_grant_rst", ch_grant, 0);
        checkOutput("t5_done_rst", ch_write_done, 0);
        checkOutput("t5_error_rst", ch_error, 0);
        checkOutput("t5_data_valid_rst", bus.write_data_valid, 0);
        checkOutput("t5_data_rst", bus.write_data, 0);
        checkOutput("t5_rows_rst", bus.write_rows, 0);
        checkOutput("t5_name_rst", bus.write_name, 0);
        checkOutput("t5_busy_rst", busy, 0);
        rst             = 1'b0;
        bus.write_ready = 1'b1;
        m_ptr           = NUM_CH - 1;
        setRequest(3, 1, 1);
        setRequest(0, 1, 2);
        driveInputs();
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);

        $display("[TB] T6 writer never completes");
        setRequest(1, 2, 2);
        driveInputs();
        @(negedge clk);
        checkOutput("t6_grant", ch_grant, oneHot(1));
        m_req[1]        = 1'b0;
        bus.write_ready = 1'b0;
        driveInputs();
`ifdef MATRIX_WRITE_TIMEOUT_EN
        cycles = 0;
        while (ch_error == '0 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("t6_timeout_error", ch_error, oneHot(1));
        checkOutput("t6_timeout_cycles", cycles, 16);
        checkOutput("t6_no_done", ch_write_done, 0);
        @(negedge clk);
        checkOutput("t6_grant_release", ch_grant, 0);
        checkOutput("t6_busy", busy, 0);
        bus.write_ready = 1'b1;
`else
        cycles = 0;
        repeat (40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("t6_grant_held", ch_grant, oneHot(1));
        checkOutput("t6_busy_held", busy, 1);
        checkOutput("t6_no_error", ch_error, 0);
        bus.write_done  = 1'b1;
        bus.write_ready = 1'b1;
        @(negedge clk);
        bus.write_done = 1'b0;
        checkOutput("t6_late_done", ch_write_done, oneHot(1));
        @(negedge clk);
        checkOutput("t6_grant_release", ch_grant, 0);
`endif
        m_ptr = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
